// File: rtl/toggle_req_gen.sv
// Debounced push-button front end: turns a bouncy button level into one
// single-cycle toggle request per accepted press, plus a press counter and busy flag.
module toggle_req_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int PCNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_in,
    output logic              t,
    output logic              busy,
    output logic [PCNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic             btn_sync;
    logic [CNT_W-1:0] cnt;

    assign btn_sync = s2;
    assign busy     = (state != IDLE);

    // The counter counts stable samples after the one that opened the
    // debounce window, so a level must be seen DEBOUNCE_CYCLES+1 times in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            t           <= 1'b0;
            press_count <= '0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
            t  <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= DB_PRESS;
                        cnt   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state       <= HELD;
                        t           <= 1'b1;
                        press_count <= press_count + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (btn_sync) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_req_gen.sv
// Bench for toggle_req_gen: directed scenarios plus randomized bouncing, all
// checked against a run-length model of the debounced button level.
module tb_toggle_req_gen;

    localparam int D  = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_in;
    logic          t;
    logic          busy;
    logic [PW-1:0] press_count;
    logic          t_out;

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    toggle_req_gen #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(8),
        .PCNT_W(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .t(t),
        .busy(busy),
        .press_count(press_count)
    );

    // Downstream T flip-flop
    always @(posedge clk) begin
        if (rst) t_out <= 1'b0;
        else if (t) t_out <= ~t_out;
    end

    // Reference: accepted level flips after D+1 consecutive synchronized
    // samples that disagree with it; a 0->1 flip is one press.
    logic          m_s1 = 1'b0;
    logic          m_s2 = 1'b0;
    logic          m_pressed = 1'b0;
    int            m_run = 0;
    logic          exp_t = 1'b0;
    logic          exp_busy = 1'b0;
    logic [PW-1:0] exp_count = '0;
    logic [PW-1:0] exp_q[$];

    always @(posedge clk) begin : ref_model
        logic bs;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_pressed = 1'b0; m_run = 0;
            exp_t = 1'b0; exp_busy = 1'b0; exp_count = '0;
            exp_q.delete();
        end else begin
            bs = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_in;
            exp_t = 1'b0;
            if (bs != m_pressed) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_pressed = bs;
                    m_run = 0;
                    if (bs) begin
                        exp_t = 1'b1;
                        exp_count = exp_count + 1'b1;
                        exp_q.push_back(exp_count);
                    end
                end
            end else begin
                m_run = 0;
            end
            exp_busy = m_pressed || (m_run != 0);
        end
    end

    task automatic test_reset();
        int first = 0;
        int pulses = 0;
        rst = 1'b1;
        btn_in = 1'b1;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if ({t, busy, press_count} !== '0) begin
                fails++;
                $display("FAIL reset_hold t/busy/count got %b/%b/%0d exp 0/0/0", t, busy, press_count);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 26; e++) begin
            btn_in = (e <= 12);
            @(negedge clk);
            tests++;
            if ({t, busy, press_count} !== {exp_t, exp_busy, exp_count}) begin
                fails++;
                $display("FAIL reset_model e=%0d t/busy/count got %b/%b/%0d exp %b/%b/%0d",
                         e, t, busy, press_count, exp_t, exp_busy, exp_count);
            end
            if (t === 1'b1) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
        tests++;
        if (first != D + 3) begin
            fails++;
            $display("FAIL reset_pulse_edge got %0d exp %0d", first, D + 3);
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL reset_pulse_count got %0d exp 1", pulses);
        end
    endtask

    task automatic test_clean_press();
        localparam int H = 10;
        int first = 0;
        int pulses = 0;
        int last_busy = 0;
        logic [PW-1:0] start_count;
        start_count = press_count;
        for (int e = 1; e <= H + 14; e++) begin
            btn_in = (e <= H);
            @(negedge clk);
            tests++;
            if ({t, busy, press_count} !== {exp_t, exp_busy, exp_count}) begin
                fails++;
                $display("FAIL clean_model e=%0d t/busy/count got %b/%b/%0d exp %b/%b/%0d",
                         e, t, busy, press_count, exp_t, exp_busy, exp_count);
            end
            if (t === 1'b1) begin
                pulses++;
                if (first == 0) first = e;
            end
            if (busy === 1'b1) last_busy = e;
        end
        tests++;
        if (first != D + 3 || pulses != 1) begin
            fails++;
            $display("FAIL clean_pulse edge/pulses got %0d/%0d exp %0d/1", first, pulses, D + 3);
        end
        tests++;
        if (last_busy != H + D + 2) begin
            fails++;
            $display("FAIL clean_busy_fall last busy edge got %0d exp %0d", last_busy, H + D + 2);
        end
        tests++;
        if (press_count !== start_count + 8'd1) begin
            fails++;
            $display("FAIL clean_count got %0d exp %0d", press_count, start_count + 8'd1);
        end
    endtask

    task automatic test_bounce();
        int first = 0;
        int pulses = 0;
        for (int e = 1; e <= 34; e++) begin
            btn_in = (e <= 4) ? e[0] : (e <= 20);
            @(negedge clk);
            tests++;
            if ({t, busy, press_count} !== {exp_t, exp_busy, exp_count}) begin
                fails++;
                $display("FAIL bounce_model e=%0d t/busy/count got %b/%b/%0d exp %b/%b/%0d",
                         e, t, busy, press_count, exp_t, exp_busy, exp_count);
            end
            if (t === 1'b1) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
        tests++;
        if (first != 5 + D + 2 || pulses != 1) begin
            fails++;
            $display("FAIL bounce_pulse edge/pulses got %0d/%0d exp %0d/1", first, pulses, 5 + D + 2);
        end
    endtask

    task automatic test_held_glitch();
        int pulses = 0;
        int last_busy = 0;
        for (int e = 1; e <= 70; e++) begin
            btn_in = (e <= 50) || (e == 53);
            @(negedge clk);
            tests++;
            if ({t, busy, press_count} !== {exp_t, exp_busy, exp_count}) begin
                fails++;
                $display("FAIL held_model e=%0d t/busy/count got %b/%b/%0d exp %b/%b/%0d",
                         e, t, busy, press_count, exp_t, exp_busy, exp_count);
            end
            if (t === 1'b1) pulses++;
            if (busy === 1'b1) last_busy = e;
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL held_pulses got %0d exp 1", pulses);
        end
        tests++;
        if (last_busy != 56 + D - 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL held_busy_fall last busy edge/busy got %0d/%b exp %0d/0", last_busy, busy, 56 + D - 1);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int first = 0;
        int pulses = 0;
        for (int e = 1; e <= 34; e++) begin
            btn_in = (e <= 20);
            rst = (e == 5);
            @(negedge clk);
            tests++;
            if ({t, busy, press_count} !== {exp_t, exp_busy, exp_count}) begin
                fails++;
                $display("FAIL rstmid_model e=%0d t/busy/count got %b/%b/%0d exp %b/%b/%0d",
                         e, t, busy, press_count, exp_t, exp_busy, exp_count);
            end
            if (t === 1'b1) begin
                pulses++;
                if (first == 0) first = e;
            end
        end
        rst = 1'b0;
        tests++;
        if (first != 6 + D + 2 || pulses != 1) begin
            fails++;
            $display("FAIL rstmid_pulse edge/pulses got %0d/%0d exp %0d/1", first, pulses, 6 + D + 2);
        end
        tests++;
        if (press_count !== 8'd1) begin
            fails++;
            $display("FAIL rstmid_count got %0d exp 1", press_count);
        end
    endtask

    task automatic test_random();
        int run_left = 0;
        logic lvl = 1'b0;
        logic [PW-1:0] v;
        exp_q.delete();
        for (int e = 1; e <= 800; e++) begin
            if (run_left == 0) begin
                lvl = ~lvl;
                run_left = $urandom_range(1, D + 4);
            end
            run_left--;
            btn_in = lvl;
            rst = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            tests++;
            if ({t, busy, press_count} !== {exp_t, exp_busy, exp_count}) begin
                fails++;
                $display("FAIL random_model e=%0d t/busy/count got %b/%b/%0d exp %b/%b/%0d",
                         e, t, busy, press_count, exp_t, exp_busy, exp_count);
            end
            if (t === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL random_scoreboard unexpected pulse e=%0d count=%0d", e, press_count);
                end else begin
                    v = exp_q.pop_front();
                    if (press_count !== v) begin
                        fails++;
                        $display("FAIL random_scoreboard count got %0d exp %0d", press_count, v);
                    end
                end
            end
        end
        rst = 1'b0;
        btn_in = 1'b0;
    endtask

    task automatic test_wrap();
        int pulses = 0;
        rst = 1'b1;
        btn_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 257; p++) begin
            for (int e = 1; e <= 16; e++) begin
                btn_in = (e <= 8);
                @(negedge clk);
                tests++;
                if ({t, busy, press_count} !== {exp_t, exp_busy, exp_count}) begin
                    fails++;
                    $display("FAIL wrap_model p=%0d e=%0d t/busy/count got %b/%b/%0d exp %b/%b/%0d",
                             p, e, t, busy, press_count, exp_t, exp_busy, exp_count);
                end
                if (t === 1'b1) pulses++;
            end
        end
        tests++;
        if (pulses != 257) begin
            fails++;
            $display("FAIL wrap_pulses got %0d exp 257", pulses);
        end
        tests++;
        if (press_count !== 8'd1) begin
            fails++;
            $display("FAIL wrap_count got %0d exp 1", press_count);
        end
        tests++;
        if (t_out !== 1'b1) begin
            fails++;
            $display("FAIL wrap_tff t_out got %b exp 1", t_out);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_held_glitch();
        test_reset_mid_debounce();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
